// File: rtl/sensor_init_seq.sv
// ---------------------------------------------------------------------------
// sensor_init_seq
//
// Purpose:
//   Walks the camera-sensor init ROM after a start pulse and turns each
//   entry into one 3-byte I2C write {reg_hi, reg_lo, data} to SLAVE_ADDR.
//   Entries whose register address equals DELAY_MARK are not written.
//   Instead they wait for data[7:0] delay_tick strobes. A NACKed write is
//   re-issued up to MAX_RETRY times before the sequence stops with error.
//   The done output gates the CSI receiver start downstream.
//
// Ports:
//   clk, rst      system clock, asynchronous active-high reset
//   start         1-cycle pulse, begins the sequence (ignored while busy)
//   rom_addr      ROM index; the ROM answers on rom_data one cycle later
//   rom_data      {reg_addr[15:0], data[7:0]}
//   i2c_req       write request, held until i2c_ack
//   i2c_addr      7-bit slave address (constant)
//   i2c_wdata     bytes to send, MSB byte first
//   i2c_ack       master accepted the request
//   i2c_done      1-cycle pulse, transaction finished
//   i2c_nack      qualifies i2c_done, slave NACKed a byte
//   delay_tick    timebase strobe used by delay entries
//   busy          sequence in progress
//   done          sticky, every entry written
//   error         sticky, an entry ran out of retries
//   err_index     index of the failing entry (valid with error)
// ---------------------------------------------------------------------------
module sensor_init_seq #(
   parameter int unsigned NUM_REGISTERS = 65,
   parameter logic [6:0]  SLAVE_ADDR    = 7'd16,
   parameter int unsigned MAX_RETRY     = 3,
   parameter logic [15:0] DELAY_MARK    = 16'hFFFF,
   localparam int unsigned AW = (NUM_REGISTERS > 1) ? $clog2(NUM_REGISTERS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic [AW-1:0] rom_addr,
   input  logic [23:0]   rom_data,
   output logic          i2c_req,
   output logic [6:0]    i2c_addr,
   output logic [23:0]   i2c_wdata,
   input  logic          i2c_ack,
   input  logic          i2c_done,
   input  logic          i2c_nack,
   input  logic          delay_tick,
   output logic          busy,
   output logic          done,
   output logic          error,
   output logic [AW-1:0] err_index
);

   // Retry counter must be able to hold MAX_RETRY itself.
   localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;

   localparam logic [AW-1:0] LAST_IDX    = AW'(NUM_REGISTERS - 1);
   localparam logic [AW-1:0] IDX_ONE     = AW'(1);
   localparam logic [RW-1:0] RETRY_LIMIT = RW'(MAX_RETRY);
   localparam logic [RW-1:0] RETRY_ONE   = RW'(1);

   typedef enum logic [2:0] {
      ST_IDLE  = 3'd0,
      ST_FETCH = 3'd1,
      ST_LATCH = 3'd2,
      ST_ISSUE = 3'd3,
      ST_WAIT  = 3'd4,
      ST_DELAY = 3'd5,
      ST_NEXT  = 3'd6
   } state_t;

   state_t          state_q,     state_d;
   logic [AW-1:0]   idx_q,       idx_d;
   logic [AW-1:0]   rom_addr_q,  rom_addr_d;
   logic            i2c_req_q,   i2c_req_d;
   logic [23:0]     i2c_wdata_q, i2c_wdata_d;
   logic            busy_q,      busy_d;
   logic            done_q,      done_d;
   logic            error_q,     error_d;
   logic [AW-1:0]   err_index_q, err_index_d;
   logic [RW-1:0]   retry_q,     retry_d;
   logic [7:0]      delay_cnt_q, delay_cnt_d;
   logic [7:0]      delay_len_q, delay_len_d;

   // State register and all registered outputs.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= ST_IDLE;
         idx_q       <= '0;
         rom_addr_q  <= '0;
         i2c_req_q   <= 1'b0;
         i2c_wdata_q <= 24'h000000;
         busy_q      <= 1'b0;
         done_q      <= 1'b0;
         error_q     <= 1'b0;
         err_index_q <= '0;
         retry_q     <= '0;
         delay_cnt_q <= 8'd0;
         delay_len_q <= 8'd0;
      end else begin
         state_q     <= state_d;
         idx_q       <= idx_d;
         rom_addr_q  <= rom_addr_d;
         i2c_req_q   <= i2c_req_d;
         i2c_wdata_q <= i2c_wdata_d;
         busy_q      <= busy_d;
         done_q      <= done_d;
         error_q     <= error_d;
         err_index_q <= err_index_d;
         retry_q     <= retry_d;
         delay_cnt_q <= delay_cnt_d;
         delay_len_q <= delay_len_d;
      end
   end

   // Next-state and next-output logic. Outputs are decided on the transition
   // into a state, so that they are already valid in the state they belong to.
   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      rom_addr_d  = rom_addr_q;
      i2c_req_d   = i2c_req_q;
      i2c_wdata_d = i2c_wdata_q;
      done_d      = done_q;
      error_d     = error_q;
      err_index_d = err_index_q;
      retry_d     = retry_q;
      delay_cnt_d = delay_cnt_q;
      delay_len_d = delay_len_q;

      case (state_q)
         ST_IDLE: begin
            // i2c_done arriving here belongs to no transaction of ours.
            if (start) begin
               done_d      = 1'b0;
               error_d     = 1'b0;
               err_index_d = '0;
               idx_d       = '0;
               rom_addr_d  = '0;
               retry_d     = '0;
               state_d     = ST_FETCH;
            end else begin
               state_d = ST_IDLE;
            end
         end

         ST_FETCH: begin
            // rom_addr is already presented; give the ROM its cycle.
            state_d = ST_LATCH;
         end

         ST_LATCH: begin
            if (rom_data[23:8] == DELAY_MARK) begin
               delay_len_d = rom_data[7:0];
               delay_cnt_d = 8'd0;
               state_d     = ST_DELAY;
            end else begin
               // i2c_wdata keeps the entry for retries.
               i2c_wdata_d = rom_data;
               i2c_req_d   = 1'b1;
               state_d     = ST_ISSUE;
            end
         end

         ST_ISSUE: begin
            if (i2c_ack) begin
               i2c_req_d = 1'b0;
               state_d   = ST_WAIT;
            end else begin
               state_d = ST_ISSUE;
            end
         end

         ST_WAIT: begin
            if (i2c_done) begin
               if (!i2c_nack) begin
                  state_d = ST_NEXT;
               end else if (retry_q < RETRY_LIMIT) begin
                  retry_d   = retry_q + RETRY_ONE;
                  i2c_req_d = 1'b1;
                  state_d   = ST_ISSUE;
               end else begin
                  error_d     = 1'b1;
                  err_index_d = idx_q;
                  retry_d     = '0;
                  state_d     = ST_IDLE;
               end
            end else begin
               state_d = ST_WAIT;
            end
         end

         ST_DELAY: begin
            // A zero-length delay leaves on the first DELAY cycle.
            if (delay_len_q == 8'd0) begin
               state_d = ST_NEXT;
            end else if (delay_tick) begin
               if ((delay_cnt_q + 8'd1) == delay_len_q) begin
                  delay_cnt_d = 8'd0;
                  state_d     = ST_NEXT;
               end else begin
                  delay_cnt_d = delay_cnt_q + 8'd1;
               end
            end else begin
               state_d = ST_DELAY;
            end
         end

         ST_NEXT: begin
            retry_d = '0;
            if (idx_q == LAST_IDX) begin
               done_d  = 1'b1;
               state_d = ST_IDLE;
            end else begin
               idx_d      = idx_q + IDX_ONE;
               rom_addr_d = idx_q + IDX_ONE;
               state_d    = ST_FETCH;
            end
         end

         default: begin
            i2c_req_d = 1'b0;
            state_d   = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   assign rom_addr  = rom_addr_q;
   assign i2c_req   = i2c_req_q;
   assign i2c_addr  = SLAVE_ADDR;
   assign i2c_wdata = i2c_wdata_q;
   assign busy      = busy_q;
   assign done      = done_q;
   assign error     = error_q;
   assign err_index = err_index_q;

endmodule

// File: tb/tb_sensor_init_seq.sv
// ---------------------------------------------------------------------------
// tb_sensor_init_seq
//
// Directed bench for sensor_init_seq with a 3-entry ROM. The I2C master and
// the registered ROM are modelled here. Expected values are the ROM contents
// and the status values the sequence should end with.
// ---------------------------------------------------------------------------
module tb_sensor_init_seq;

   logic        clk;
   logic        rst;
   logic        start;
   logic [1:0]  rom_addr;
   logic [23:0] rom_data;
   logic        i2c_req;
   logic [6:0]  i2c_addr;
   logic [23:0] i2c_wdata;
   logic        i2c_ack;
   logic        i2c_done;
   logic        i2c_nack;
   logic        delay_tick;
   logic        busy;
   logic        done;
   logic        error;
   logic [1:0]  err_index;

   logic [23:0] rom_mem [0:3];

   int n_cmp = 0;
   int n_err = 0;

   sensor_init_seq #(
      .NUM_REGISTERS (3),
      .SLAVE_ADDR    (7'd16),
      .MAX_RETRY     (3),
      .DELAY_MARK    (16'hFFFF)
   ) dut (
      .clk        (clk),
      .rst        (rst),
      .start      (start),
      .rom_addr   (rom_addr),
      .rom_data   (rom_data),
      .i2c_req    (i2c_req),
      .i2c_addr   (i2c_addr),
      .i2c_wdata  (i2c_wdata),
      .i2c_ack    (i2c_ack),
      .i2c_done   (i2c_done),
      .i2c_nack   (i2c_nack),
      .delay_tick (delay_tick),
      .busy       (busy),
      .done       (done),
      .error      (error),
      .err_index  (err_index)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Registered ROM: data follows the address by one clock.
   always @(posedge clk) rom_data <= rom_mem[rom_addr];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // One I2C write as seen by the master: wait for req, check data, accept,
   // then finish with ACK (nack=0) or NACK (nack=1).
   task automatic serve(input logic nack, input logic [23:0] exp, input string tag);
      for (int k = 0; k < 40 && i2c_req !== 1'b1; k++) tick();
      check({tag, "_req"}, 32'(i2c_req), 32'd1);
      check({tag, "_wdata"}, 32'(i2c_wdata), 32'(exp));
      i2c_ack = 1'b1;
      tick();
      i2c_ack = 1'b0;
      check({tag, "_reqdrop"}, 32'(i2c_req), 32'd0);
      tick();
      tick();
      i2c_done = 1'b1;
      i2c_nack = nack;
      tick();
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      tick();
      start = 1'b0;
   endtask

   task automatic wait_done();
      for (int k = 0; k < 20 && done !== 1'b1; k++) tick();
   endtask

   initial begin
      rst        = 1'b1;
      start      = 1'b0;
      i2c_ack    = 1'b0;
      i2c_done   = 1'b0;
      i2c_nack   = 1'b0;
      delay_tick = 1'b0;
      rom_mem[0] = 24'h010000;
      rom_mem[1] = 24'h011401;
      rom_mem[2] = 24'h017203;
      rom_mem[3] = 24'h000000;
      tick();
      tick();

      // Reset state
      check("rst_busy", 32'(busy), 32'd0);
      check("rst_done", 32'(done), 32'd0);
      check("rst_error", 32'(error), 32'd0);
      check("rst_req", 32'(i2c_req), 32'd0);
      check("rst_wdata", 32'(i2c_wdata), 32'd0);
      check("rst_rom_addr", 32'(rom_addr), 32'd0);
      check("rst_err_index", 32'(err_index), 32'd0);
      check("slave_addr", 32'(i2c_addr), 32'd16);
      rst = 1'b0;
      tick();

      // 1: clean three-entry sequence
      pulse_start();
      check("t1_busy", 32'(busy), 32'd1);
      serve(1'b0, 24'h010000, "t1_e0");
      serve(1'b0, 24'h011401, "t1_e1");
      serve(1'b0, 24'h017203, "t1_e2");
      wait_done();
      check("t1_done", 32'(done), 32'd1);
      check("t1_error", 32'(error), 32'd0);
      check("t1_busy_low", 32'(busy), 32'd0);
      for (int k = 0; k < 5; k++) tick();
      check("t1_no_extra_req", 32'(i2c_req), 32'd0);

      // 2: entry 1 NACKed twice, then accepted
      pulse_start();
      check("t2_done_cleared", 32'(done), 32'd0);
      serve(1'b0, 24'h010000, "t2_e0");
      serve(1'b1, 24'h011401, "t2_e1a");
      serve(1'b1, 24'h011401, "t2_e1b");
      serve(1'b0, 24'h011401, "t2_e1c");
      serve(1'b0, 24'h017203, "t2_e2");
      wait_done();
      check("t2_done", 32'(done), 32'd1);
      check("t2_error", 32'(error), 32'd0);

      // 3: entry 1 NACKed four times, giving up
      pulse_start();
      serve(1'b0, 24'h010000, "t3_e0");
      serve(1'b1, 24'h011401, "t3_e1a");
      serve(1'b1, 24'h011401, "t3_e1b");
      serve(1'b1, 24'h011401, "t3_e1c");
      serve(1'b1, 24'h011401, "t3_e1d");
      check("t3_error", 32'(error), 32'd1);
      check("t3_err_index", 32'(err_index), 32'd1);
      check("t3_busy_low", 32'(busy), 32'd0);
      check("t3_done", 32'(done), 32'd0);
      for (int k = 0; k < 8; k++) tick();
      check("t3_no_entry2", 32'(i2c_req), 32'd0);

      // 4: delay entry of 5 ticks; a tick in LATCH is not counted
      rom_mem[1] = 24'hFFFF05;
      pulse_start();
      check("t4_error_cleared", 32'(error), 32'd0);
      serve(1'b0, 24'h010000, "t4_e0");
      tick();
      tick();
      delay_tick = 1'b1;
      tick();
      delay_tick = 1'b0;
      for (int n = 0; n < 4; n++) begin
         delay_tick = 1'b1;
         tick();
         delay_tick = 1'b0;
         tick();
         tick();
         check("t4_no_req_during_delay", 32'(i2c_req), 32'd0);
      end
      for (int k = 0; k < 4; k++) tick();
      check("t4_no_req_after_4", 32'(i2c_req), 32'd0);
      check("t4_busy_in_delay", 32'(busy), 32'd1);
      delay_tick = 1'b1;
      tick();
      delay_tick = 1'b0;
      serve(1'b0, 24'h017203, "t4_e2");
      wait_done();
      check("t4_done", 32'(done), 32'd1);
      rom_mem[1] = 24'h011401;

      // 5: reset while waiting for i2c_done
      pulse_start();
      serve(1'b0, 24'h010000, "t5_e0");
      for (int k = 0; k < 40 && i2c_req !== 1'b1; k++) tick();
      i2c_ack = 1'b1;
      tick();
      i2c_ack = 1'b0;
      #1;
      rst = 1'b1;
      #1;
      check("t5_rst_busy", 32'(busy), 32'd0);
      check("t5_rst_req", 32'(i2c_req), 32'd0);
      check("t5_rst_wdata", 32'(i2c_wdata), 32'd0);
      check("t5_rst_rom_addr", 32'(rom_addr), 32'd0);
      check("t5_rst_done", 32'(done), 32'd0);
      tick();
      rst = 1'b0;
      i2c_done = 1'b1;
      tick();
      i2c_done = 1'b0;
      tick();
      tick();
      check("t5_late_done_busy", 32'(busy), 32'd0);
      check("t5_late_done_req", 32'(i2c_req), 32'd0);
      check("t5_late_done_done", 32'(done), 32'd0);
      pulse_start();
      serve(1'b0, 24'h010000, "t5_r0");
      serve(1'b0, 24'h011401, "t5_r1");
      serve(1'b0, 24'h017203, "t5_r2");
      wait_done();
      check("t5_done", 32'(done), 32'd1);

      // 6: start while busy and i2c_done in IDLE are ignored
      pulse_start();
      for (int k = 0; k < 40 && i2c_req !== 1'b1; k++) tick();
      pulse_start();
      check("t6_busy_kept", 32'(busy), 32'd1);
      check("t6_req_kept", 32'(i2c_req), 32'd1);
      serve(1'b0, 24'h010000, "t6_e0");
      pulse_start();
      serve(1'b0, 24'h011401, "t6_e1");
      serve(1'b0, 24'h017203, "t6_e2");
      wait_done();
      check("t6_done", 32'(done), 32'd1);
      i2c_done = 1'b1;
      i2c_nack = 1'b1;
      tick();
      i2c_done = 1'b0;
      i2c_nack = 1'b0;
      for (int k = 0; k < 4; k++) tick();
      check("t6_idle_done", 32'(done), 32'd1);
      check("t6_idle_error", 32'(error), 32'd0);
      check("t6_idle_busy", 32'(busy), 32'd0);
      check("t6_idle_req", 32'(i2c_req), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule
